// File: rtl/atanh_search.sv
// Inverse tanh by binary search over an external registered tanh LUT.
// Define ATANH_EARLY_SAT_EN to finish saturated requests right after the range probe.
module atanh_search (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_y,
   output logic       in_ready,
   output logic [7:0] lut_addr,
   input  logic [7:0] lut_data,
   output logic       out_valid,
   output logic [7:0] out_x,
   output logic       out_sat,
   input  logic       out_ready
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] PROBE_SAT = 2'd1;
   localparam logic [1:0] SEARCH    = 2'd2;
   localparam logic [1:0] DONE      = 2'd3;

   logic [1:0] state_q, state_d;
   logic       sign_q, sign_d;
   logic [7:0] mag_q, mag_d;
   logic [6:0] c_q, c_d;
   logic [2:0] bit_q, bit_d;
   logic       sat_q, sat_d;
   logic [7:0] lut_addr_q, lut_addr_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_x_q, out_x_d;
   logic       out_sat_q, out_sat_d;

   logic [7:0] in_mag;
   logic       probe_lt;
   logic [6:0] bit_mask;
   logic [6:0] c_upd;
   logic [7:0] r;

   assign in_ready  = (state_q == IDLE);
   assign lut_addr  = lut_addr_q;
   assign out_valid = out_valid_q;
   assign out_x     = out_x_q;
   assign out_sat   = out_sat_q;

   // -128 has no positive 8-bit counterpart, so it folds onto the largest magnitude
   always_comb begin
      if (in_y == 8'h80)
         in_mag = 8'd127;
      else if (in_y[7])
         in_mag = -in_y;
      else
         in_mag = in_y;
   end

   assign probe_lt = $signed(lut_data) < $signed(mag_q);
   assign bit_mask = 7'd1 << bit_q;
   assign c_upd    = probe_lt ? (c_q | bit_mask) : c_q;

   always_comb begin
      if (mag_q == 8'd0)
         r = 8'd0;
      else if (sat_q)
         r = 8'h7F;
      else
         r = {1'b0, c_upd} + 8'd1;
   end

   // NOTE: every next-state signal takes its current value first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      mag_d       = mag_q;
      c_d         = c_q;
      bit_d       = bit_q;
      sat_d       = sat_q;
      lut_addr_d  = lut_addr_q;
      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      out_sat_d   = out_sat_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d     = in_y[7];
               mag_d      = in_mag;
               lut_addr_d = 8'h7F;
               state_d    = PROBE_SAT;
            end
         end
         PROBE_SAT: begin
            bit_d = 3'd6;
            if (probe_lt) begin
               sat_d = 1'b1;
               c_d   = 7'h7F;
`ifdef ATANH_EARLY_SAT_EN
               out_x_d   = sign_q ? 8'h81 : 8'h7F;
               out_sat_d = 1'b1;
               state_d   = DONE;
`else
               state_d   = SEARCH;
`endif
            end else begin
               sat_d      = 1'b0;
               c_d        = 7'd0;
               lut_addr_d = 8'h40;
               state_d    = SEARCH;
            end
         end
         SEARCH: begin
            c_d = c_upd;
            if (bit_q != 3'd0) begin
               lut_addr_d = {1'b0, c_upd | (bit_mask >> 1)};
               bit_d      = bit_q - 3'd1;
            end else begin
               out_x_d     = sign_q ? -r : r;
               out_sat_d   = sat_q;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            // the early-saturation path enters here with out_valid still low
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         mag_q       <= 8'd0;
         c_q         <= 7'd0;
         bit_q       <= 3'd0;
         sat_q       <= 1'b0;
         lut_addr_q  <= 8'd0;
         out_valid_q <= 1'b0;
         out_x_q     <= 8'd0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         mag_q       <= mag_d;
         c_q         <= c_d;
         bit_q       <= bit_d;
         sat_q       <= sat_d;
         lut_addr_q  <= lut_addr_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_sat_q   <= out_sat_d;
      end
   end

endmodule

// File: tb/tb_atanh_search.sv
// Self-checking bench for atanh_search against a tanh LUT of floor(64*tanh(a/64)).
module tb_atanh_search;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_y;
   logic       in_ready;
   logic [7:0] lut_addr;
   logic [7:0] lut_data;
   logic       out_valid;
   logic [7:0] out_x;
   logic       out_sat;
   logic       out_ready;

   logic [7:0] lut_mem [0:127];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   // reference transaction state: 0 idle, 1 computing, 2 result presented
   int         ph      = 0;
   int         cnt     = 0;
   int         exp_lat = 8;
   logic [8:0] exp_res = 9'd0;

   atanh_search dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_y      (in_y),
      .in_ready  (in_ready),
      .lut_addr  (lut_addr),
      .lut_data  (lut_data),
      .out_valid (out_valid),
      .out_x     (out_x),
      .out_sat   (out_sat),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      for (int a = 0; a < 128; a++) begin
         real e;
         e = $exp(2.0 * real'(a) / 64.0);
         lut_mem[a] = 8'($rtoi(64.0 * (e - 1.0) / (e + 1.0)));
      end
   end

   always @(negedge clk) lut_data <= lut_mem[lut_addr[6:0]];
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // {sat, x}: smallest a with lut(a) >= |y|, signed back onto y's sign
   function automatic logic [8:0] ref_result(input logic [7:0] y);
      int yi, mag, r;
      logic sat;
      logic [7:0] x;
      yi  = int'($signed(y));
      mag = (yi < 0) ? -yi : yi;
      if (mag > 127) mag = 127;
      r   = -1;
      for (int a = 127; a >= 0; a--)
         if (int'($signed(lut_mem[a])) >= mag) r = a;
      sat = (r < 0);
      if (sat) r = 127;
      x = (yi < 0) ? 8'(-r) : 8'(r);
      return {sat, x};
   endfunction

   function automatic int lat_for(input logic [8:0] res);
`ifdef ATANH_EARLY_SAT_EN
      return res[8] ? 2 : 8;
`else
      return 8;
`endif
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         ph <= 0;
      end else begin
         case (ph)
            0: if (in_valid) begin
               exp_res <= ref_result(in_y);
               exp_lat <= lat_for(ref_result(in_y));
               cnt     <= 0;
               ph      <= 1;
            end
            1: begin
               cnt <= cnt + 1;
               if (cnt + 1 == exp_lat) ph <= 2;
            end
            default: if (out_ready) ph <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", 32'(in_ready), 32'(ph == 0));
         check("out_valid", 32'(out_valid), 32'(ph == 2));
         check("lut_addr_range", 32'(lut_addr[7]), 32'd0);
         if (ph == 2 && out_valid) begin
            check("out_x", 32'(out_x), 32'(exp_res[7:0]));
            check("out_sat", 32'(out_sat), 32'(exp_res[8]));
         end
      end
   end

   task automatic wait_ready();
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (w >= 40) check("ready_timeout", 32'd0, 32'd1);
   endtask

   // issue y, hold out_ready, compare against literal expectations
   task automatic run_req(input logic [7:0] y, input logic [7:0] ex, input logic es, input int elat);
      int lat = 0;
      out_ready = 1'b1;
      in_y      = y;
      in_valid  = 1'b1;
      wait_ready();
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_y     = 8'($urandom);
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(elat));
      check("lit_out_x", 32'(out_x), 32'(ex));
      check("lit_out_sat", 32'(out_sat), 32'(es));
      @(posedge clk); #1;
   endtask

   task automatic run_rand();
      int  w = 0;
      bit  hs = 1'b0;
      in_y      = 8'($urandom);
      in_valid  = 1'b1;
      out_ready = 1'($urandom);
      wait_ready();
      @(posedge clk); #1;
      while (!hs && w < 60) begin
         in_valid  = 1'($urandom);
         in_y      = 8'($urandom);
         out_ready = 1'($urandom);
         @(negedge clk);
         hs = out_valid && out_ready;
         @(posedge clk); #1;
         w++;
      end
      if (!hs) check("handshake_timeout", 32'd0, 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_y      = 8'd0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_x", 32'(out_x), 32'd0);
      check("rst_out_sat", 32'(out_sat), 32'd0);
      check("rst_lut_addr", 32'(lut_addr), 32'd0);

      // hand-derived pins for the reference model
      check("model_1d", 32'(ref_result(8'h1D)), 32'h020);
      check("model_e3", 32'(ref_result(8'hE3)), 32'h0E0);
      check("model_00", 32'(ref_result(8'h00)), 32'h000);
      check("model_3d", 32'(ref_result(8'h3D)), 32'h078);
      check("model_3e", 32'(ref_result(8'h3E)), 32'h17F);
      check("model_80", 32'(ref_result(8'h80)), 32'h181);

      rst = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;

      run_req(8'h1D, 8'h20, 1'b0, 8);
      run_req(8'hE3, 8'hE0, 1'b0, 8);
      run_req(8'h00, 8'h00, 1'b0, 8);
      run_req(8'h3D, 8'h78, 1'b0, 8);
`ifdef ATANH_EARLY_SAT_EN
      run_req(8'h3E, 8'h7F, 1'b1, 2);
      run_req(8'h80, 8'h81, 1'b1, 2);
`else
      run_req(8'h3E, 8'h7F, 1'b1, 8);
      run_req(8'h80, 8'h81, 1'b1, 8);
`endif

      // backpressure: result must hold and new requests must be ignored
      begin
         int lat = 0;
         out_ready = 1'b0;
         in_y      = 8'hE3;
         in_valid  = 1'b1;
         wait_ready();
         @(posedge clk); #1;
         in_valid = 1'b0;
         while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
         end
         check("bp_latency", 32'(lat), 32'd8);
         for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_y     = 8'h55;
            @(posedge clk); #1;
            check("bp_out_x", 32'(out_x), 32'hE0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(posedge clk); #1;
         check("bp_release_valid", 32'(out_valid), 32'd0);
         check("bp_release_ready", 32'(in_ready), 32'd1);
      end

      // reset in the middle of a search discards the operation
      in_y     = 8'h1D;
      in_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_x", 32'(out_x), 32'd0);
      check("midrst_out_sat", 32'(out_sat), 32'd0);
      check("midrst_lut_addr", 32'(lut_addr), 32'd0);
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      run_req(8'h3D, 8'h78, 1'b0, 8);

      for (int i = 0; i < 60; i++) run_rand();
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/atanh_search.md
ATANH_SEARCH -- requirements
Module: atanh_search

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  in  1  request strobe; in_y  in  8  signed target (two's complement, LUT output format); in_ready  out  1  high only in IDLE.
REQ-004 SHALL have: lut_addr  out  8  registered address to tanh LUT; lut_data  in  8  LUT output, updated on LUT's falling edge, valid at next rising edge.
REQ-005 SHALL have: out_valid  out  1; out_x  out  8  signed result (LUT input format); out_sat  out  1  target beyond LUT range; out_ready  in  1.

Function
REQ-006 SHALL compute inverse tanh by searching the tanh LUT: smallest a in 0..127 with lut(a) >= mag.
REQ-007 SHALL derive mag = |in_y|; in_y = 0x80 SHALL give mag = 127.
REQ-008 SHALL register in_y sign and mag on accept (in_valid & in_ready).
REQ-009 SHALL use states IDLE, PROBE_SAT, SEARCH, DONE.
REQ-010 IDLE: on accept, lut_addr <= 0x7F, go PROBE_SAT.
REQ-011 PROBE_SAT: if lut_data < mag, sat <= 1, c <= 0x7F; else sat <= 0, c <= 0, lut_addr <= 0x40; go SEARCH with bit index 6.
REQ-012 SEARCH, per cycle for bit b = 6..0: if lut_data < mag then c <= c | (1<<b); next probe address = updated c | (1<<(b-1)); one probe per cycle.
REQ-013 After bit 0: result r = 0 if mag = 0; r = 0x7F if sat; else r = c + 1.
REQ-014 out_x SHALL be r when in_y >= 0, else -r (two's complement, 8 bits).
REQ-015 out_valid SHALL rise exactly 8 cycles after the accept edge (without early exit, see REQ-021); DONE holds out_x/out_sat stable until out_valid & out_ready.
REQ-016 On out_valid & out_ready: out_valid <= 0, go IDLE; in_ready rises the following cycle (no same-cycle re-accept).
REQ-017 in_valid outside IDLE SHALL be ignored; in_y changes after accept SHALL not affect result.
REQ-018 Comparisons SHALL be signed 8-bit; lut_addr SHALL never exceed 0x7F.

Reset
REQ-019 rst SHALL force state IDLE, in_ready = 1, out_valid = 0, out_x = 0x00, out_sat = 0, lut_addr = 0x00, c = 0 on the next rising edge.
REQ-020 rst mid-search or in DONE SHALL discard the operation; no out_valid pulse follows.

Configuration
REQ-021 Macro ATANH_EARLY_SAT_EN: defined -> PROBE_SAT with sat = 1 goes directly to DONE, out_valid 2 cycles after accept; undefined -> fixed 8-cycle latency for all inputs, saturated case idles through SEARCH with result unchanged.

Verification
REQ-022 in_y = 0x1D, out_ready = 1 -> out_x = 0x20, out_sat = 0, out_valid 8 cycles after accept.
REQ-023 in_y = 0xE3 -> out_x = 0xE0, out_sat = 0; in_y = 0x00 -> out_x = 0x00; in_y = 0x3D -> out_x = 0x78.
REQ-024 in_y = 0x3E and in_y = 0x80 -> out_x = 0x7F / 0x81, out_sat = 1; latency 2 with ATANH_EARLY_SAT_EN, 8 without.
REQ-025 out_ready held low 5 cycles after out_valid -> out_x stable, in_ready = 0, second in_valid ignored; out_ready high -> IDLE next cycle.
REQ-026 rst asserted at search cycle 4 -> next cycle all outputs at reset values, no out_valid; new request then completes normally.
